// File: rtl/store_pkg.sv
// Shared store-path definitions: op encodings, queued-entry layout and
// byte-enable helpers used by the store buffer and the lane aligner.
package store_pkg;

    // Widest byte address a queued entry can carry.
    localparam int ADDR_W = 32;

    // All four byte lanes enabled (full-word store).
    localparam logic [3:0] BE_ALL = 4'hF;

    // MEM-stage store opcode as presented on in_op.
    typedef enum logic [1:0] {
        OP_SB  = 2'b00,
        OP_SH  = 2'b01,
        OP_SW  = 2'b10,
        OP_RSV = 2'b11
    } store_op_e;

    // One queued store: word-aligned address, lane-replicated data, byte enables.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
    } store_entry_t;

    // Single-byte enable for a byte offset within the word.
    function automatic logic [3:0] byte_be(input logic [1:0] offset);
        return 4'b0001 << offset;
    endfunction

    // Halfword enable: the upper or lower lane pair, chosen by offset bit 1.
    function automatic logic [3:0] half_be(input logic [1:0] offset);
        return offset[1] ? 4'b1100 : 4'b0011;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane aligner: maps a store op, byte address and register
// value onto byte enables and replicated write data for a 32-bit memory word.
// Kept standalone so the load byte-select path can reuse the same decode.
module store_lane_align
    import store_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [1:0]    op_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   data_i,
    output logic          legal_o,
    output logic [3:0]    be_o,
    output logic [31:0]   wdata_o,
    output logic [AW-1:0] aligned_addr_o
);

    logic [1:0] offset;
    store_op_e  op;

    assign offset         = addr_i[1:0];
    assign op             = store_op_e'(op_i);
    assign aligned_addr_o = {addr_i[AW-1:2], 2'b00};

    // Per-lane data source: bytes replicate the low byte into every lane,
    // halfwords replicate the low halfword into both lane pairs, and words
    // pass straight through. Lanes outside the enable carry don't-care data.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_byte;

            // Select the source byte for lane gi from the op.
            always_comb begin
                lane_byte = 8'h00;
                case (op)
                    OP_SB:   lane_byte = data_i[7:0];
                    OP_SH:   lane_byte = data_i[8*(gi%2) +: 8];
                    OP_SW:   lane_byte = data_i[8*gi +: 8];
                    OP_RSV:  lane_byte = 8'h00;
                    default: lane_byte = 8'h00;
                endcase
            end

            assign wdata_o[8*gi +: 8] = lane_byte;
        end
    endgenerate

    // Legality and byte-enable decode; misaligned and reserved ops enable no lanes.
    always_comb begin
        legal_o = 1'b0;
        be_o    = 4'b0000;
        case (op)
            OP_SB: begin
                legal_o = 1'b1;
                be_o    = byte_be(offset);
            end
            OP_SH: begin
                legal_o = ~offset[0];
                be_o    = offset[0] ? 4'b0000 : half_be(offset);
            end
            OP_SW: begin
                legal_o = (offset == 2'b00);
                be_o    = (offset == 2'b00) ? BE_ALL : 4'b0000;
            end
            OP_RSV: begin
                legal_o = 1'b0;
                be_o    = 4'b0000;
            end
            default: begin
                legal_o = 1'b0;
                be_o    = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow_buffer.sv
// Store narrowing buffer: aligns committed stores onto byte lanes, reports
// misaligned/reserved stores as a one-cycle address error, and queues legal
// stores in a small in-order FIFO draining to data memory via valid/ready.
module store_narrow_buffer
    import store_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [AW-1:0]            in_addr,
    input  logic [31:0]              in_data,
    output logic                     ades,
    output logic [AW-1:0]            ades_addr,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [AW-1:0]            mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Queue state.
    store_entry_t    fifo_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            ades_q,   ades_d;
    logic [AW-1:0]   ades_addr_q, ades_addr_d;

    // Aligner outputs for the store currently presented.
    logic            st_legal;
    logic [3:0]      st_be;
    logic [31:0]     st_wdata;
    logic [AW-1:0]   st_addr;

    logic            full;
    logic            empty;
    logic            accept;
    logic            enq;
    logic            deq;
    store_entry_t    new_entry;
    store_entry_t    head_entry;

    store_lane_align #(
        .AW (AW)
    ) u_align (
        .op_i           (in_op),
        .addr_i         (in_addr),
        .data_i         (in_data),
        .legal_o        (st_legal),
        .be_o           (st_be),
        .wdata_o        (st_wdata),
        .aligned_addr_o (st_addr)
    );

    // Full blocks intake outright: a same-cycle dequeue does not free a slot
    // for the incoming store, so in_ready depends only on registered state.
    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign accept = in_valid && !full;
    assign enq    = accept && st_legal;
    assign deq    = !empty && mem_ready;

    assign new_entry.addr  = ADDR_W'(st_addr);
    assign new_entry.wdata = st_wdata;
    assign new_entry.be    = st_be;

    // Next-state for pointers, occupancy and the address-error report.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ades_d      = accept && !st_legal;
        ades_addr_d = ades_addr_q;

        if (enq) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (accept && !st_legal) begin
            ades_addr_d = in_addr;
        end
    end

    // Control registers; reset drops every queued entry and any pending error.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ades_q      <= 1'b0;
            ades_addr_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ades_q      <= ades_d;
            ades_addr_q <= ades_addr_d;
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_mem[wr_ptr_q] <= new_entry;
        end
    end

    // Head entry drives memory directly, giving one-cycle accept-to-valid
    // latency; outputs read as zero while the queue is empty.
    assign head_entry = fifo_mem[rd_ptr_q];

    assign in_ready  = !full;
    assign mem_valid = !empty;
    assign mem_addr  = empty ? '0 : AW'(head_entry.addr);
    assign mem_wdata = empty ? '0 : head_entry.wdata;
    assign mem_be    = empty ? '0 : head_entry.be;
    assign count     = count_q;
    assign ades      = ades_q;
    assign ades_addr = ades_addr_q;
    assign idle      = empty && !ades_q;

endmodule
